// File: rtl/mt_thread_sched.sv
// Barrel-style thread scheduler for the 8-thread, two-group banked register file.
// Define MT_SCHED_PERF_EN to build the idle_cycles performance counter; otherwise it reads 0.
module mt_thread_sched #(
  parameter int NUM_THREADS  = 8,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int WB_LATENCY   = 2,
  parameter int GRP_QUANTUM  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_THREADS-1:0]  thread_en,
  input  logic                    stall_valid,
  input  logic [BITS_THREADS-1:0] stall_tid,
  input  logic                    wake_valid,
  input  logic [BITS_THREADS-1:0] wake_tid,
  input  logic                    pipe_hold,
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] issue_tid,
  output logic                    tgrp,
  output logic                    wb_valid,
  output logic [BITS_THREADS-1:0] wb_tid,
  output logic [31:0]             idle_cycles
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  localparam int         HALF    = NUM_THREADS / 2;
  localparam logic [7:0] QUANTUM = 8'(GRP_QUANTUM);

  state_t                                  state_q, state_d;
  logic                                    tgrp_q, tgrp_d;
  logic [7:0]                              qcnt_q, qcnt_d;
  logic [BITS_THREADS-1:0]                 last_tid_q, last_tid_d;
  logic [NUM_THREADS-1:0]                  stall_q, stall_d;
  logic [NUM_THREADS-1:0]                  inflight_q, inflight_d;
  logic [WB_LATENCY-1:0]                   pipe_v_q, pipe_v_d;
  logic [WB_LATENCY-1:0][BITS_THREADS-1:0] pipe_tid_q, pipe_tid_d;

  logic [NUM_THREADS-1:0]  ready, eligible;
  logic                    cur_rdy, other_rdy, run_ok, pipe_head_busy;
  logic [BITS_THREADS-1:0] cand;
  logic [7:0]              qcnt_inc;

  function automatic logic [NUM_THREADS-1:0] tid_mask(input logic en, input logic [BITS_THREADS-1:0] tid);
    tid_mask = {{(NUM_THREADS-1){1'b0}}, en} << tid;
  endfunction

  assign ready     = thread_en & ~stall_q;
  assign cur_rdy   = tgrp_q ? |ready[NUM_THREADS-1:HALF] : |ready[HALF-1:0];
  assign other_rdy = tgrp_q ? |ready[HALF-1:0] : |ready[NUM_THREADS-1:HALF];
  assign run_ok    = (state_q == ST_RUN) && !pipe_hold;
  assign wb_valid  = pipe_v_q[WB_LATENCY-1] & ~pipe_hold;
  assign wb_tid    = pipe_tid_q[WB_LATENCY-1];
  assign tgrp      = tgrp_q;

  // Output logic: round-robin pick that keeps the reader off the writeback bank parity.
  always_comb begin
    eligible    = {NUM_THREADS{1'b0}};
    issue_valid = 1'b0;
    issue_tid   = {BITS_THREADS{1'b0}};
    cand        = last_tid_q;
    for (int i = 0; i < NUM_THREADS; i++) begin
      eligible[i] = run_ok && ready[i] && (i[BITS_THREADS-1] == tgrp_q) && !inflight_q[i]
                    && !(wb_valid && (i[0] == wb_tid[0]));
    end
    for (int off = 1; off <= NUM_THREADS; off++) begin
      cand        = last_tid_q + BITS_THREADS'(off);
      issue_tid   = (!issue_valid && eligible[cand]) ? cand : issue_tid;
      issue_valid = issue_valid | eligible[cand];
    end
  end

  // Next-state logic: quantum accounting and group drain/switch.
  always_comb begin
    state_d        = state_q;
    tgrp_d         = tgrp_q;
    qcnt_d         = qcnt_q;
    last_tid_d     = last_tid_q;
    qcnt_inc       = qcnt_q + {7'd0, issue_valid};
    pipe_head_busy = 1'b0;
    for (int k = 0; k < WB_LATENCY - 1; k++) begin
      pipe_head_busy = pipe_head_busy | pipe_v_q[k];
    end
    if (pipe_hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          last_tid_d = issue_valid ? issue_tid : last_tid_q;
          if (other_rdy && ((qcnt_inc == QUANTUM) || !cur_rdy)) begin
            state_d = ST_DRAIN;
            qcnt_d  = qcnt_inc;
          end else if (qcnt_inc == QUANTUM) begin
            qcnt_d = 8'd0;
          end else begin
            qcnt_d = qcnt_inc;
          end
        end
        ST_DRAIN: begin
          // The tail entry may still be writing back; it belongs to the old group but the switch lands after it.
          if (!pipe_head_busy) begin
            state_d = ST_RUN;
            tgrp_d  = ~tgrp_q;
            qcnt_d  = 8'd0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Datapath next state: stall bits, in-flight bits and writeback pipe.
  always_comb begin
    stall_d    = (stall_q | tid_mask(stall_valid, stall_tid)) & ~tid_mask(wake_valid, wake_tid);
    inflight_d = pipe_hold ? inflight_q
               : ((inflight_q & ~tid_mask(wb_valid, wb_tid)) | tid_mask(issue_valid, issue_tid));
    pipe_v_d   = pipe_v_q;
    pipe_tid_d = pipe_tid_q;
    if (pipe_hold) begin
      pipe_v_d = pipe_v_q;
    end else begin
      pipe_v_d[0]   = issue_valid;
      pipe_tid_d[0] = issue_tid;
      for (int k = 1; k < WB_LATENCY; k++) begin
        pipe_v_d[k]   = pipe_v_q[k-1];
        pipe_tid_d[k] = pipe_tid_q[k-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgrp_q     <= 1'b0;
      qcnt_q     <= 8'd0;
      last_tid_q <= {BITS_THREADS{1'b1}};
      stall_q    <= {NUM_THREADS{1'b0}};
      inflight_q <= {NUM_THREADS{1'b0}};
      pipe_v_q   <= {WB_LATENCY{1'b0}};
      pipe_tid_q <= {(WB_LATENCY*BITS_THREADS){1'b0}};
    end else begin
      tgrp_q     <= tgrp_d;
      qcnt_q     <= qcnt_d;
      last_tid_q <= last_tid_d;
      stall_q    <= stall_d;
      inflight_q <= inflight_d;
      pipe_v_q   <= pipe_v_d;
      pipe_tid_q <= pipe_tid_d;
    end
  end

`ifdef MT_SCHED_PERF_EN
  logic [31:0] idle_q, idle_d;

  // Saturating count of unheld cycles without an issue.
  always_comb begin
    idle_d = (!pipe_hold && !issue_valid && (idle_q != 32'hFFFF_FFFF)) ? idle_q + 32'd1 : idle_q;
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= 32'd0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign idle_cycles = idle_q;
`else
  assign idle_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mt_thread_sched.sv
// Self-checking bench for mt_thread_sched: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mt_thread_sched;

  localparam int NT = 8;
  localparam int L  = 2;
  localparam int Q  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  thread_en = 8'h00;
  logic        stall_valid = 1'b0;
  logic [2:0]  stall_tid = 3'd0;
  logic        wake_valid = 1'b0;
  logic [2:0]  wake_tid = 3'd0;
  logic        pipe_hold = 1'b0;
  logic        issue_valid;
  logic [2:0]  issue_tid;
  logic        tgrp;
  logic        wb_valid;
  logic [2:0]  wb_tid;
  logic [31:0] idle_cycles;

  always #5 clk = ~clk;

  mt_thread_sched #(.NUM_THREADS(NT), .WB_LATENCY(L), .GRP_QUANTUM(Q)) dut (
    .clk(clk), .rst(rst), .thread_en(thread_en),
    .stall_valid(stall_valid), .stall_tid(stall_tid),
    .wake_valid(wake_valid), .wake_tid(wake_tid),
    .pipe_hold(pipe_hold), .issue_valid(issue_valid), .issue_tid(issue_tid),
    .tgrp(tgrp), .wb_valid(wb_valid), .wb_tid(wb_tid), .idle_cycles(idle_cycles)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: the pipe is a list of pending tids (-1 = bubble);
  // a thread is in flight exactly when it appears in that list.
  int      m_pipe[L];
  bit [7:0] m_stall;
  int      m_last, m_qcnt;
  bit      m_tgrp, m_drain;
  longint  m_idle;
  bit      e_iv, e_wbv;
  int      e_tid, e_wbt;

  function automatic bit in_flight(input int t);
    for (int k = 0; k < L; k++) if (m_pipe[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    int t;
    e_wbv = (m_pipe[L-1] >= 0) && !pipe_hold;
    e_wbt = m_pipe[L-1];
    e_iv  = 1'b0;
    e_tid = 0;
    if (!m_drain && !pipe_hold) begin
      for (int off = 1; off <= NT; off++) begin
        t = (m_last + off) % NT;
        if (!e_iv && thread_en[t] && !m_stall[t] && ((t / 4) == int'(m_tgrp)) && !in_flight(t)
            && !(e_wbv && ((t % 2) == (e_wbt % 2)))) begin
          e_iv  = 1'b1;
          e_tid = t;
        end
      end
    end
  endtask

  task automatic model_step();
    int q;
    bit cur, oth, busy;
    if (rst) begin
      for (int k = 0; k < L; k++) m_pipe[k] = -1;
      m_stall = 8'h00; m_last = 7; m_qcnt = 0; m_tgrp = 1'b0; m_drain = 1'b0; m_idle = 0;
      return;
    end
    if (!pipe_hold) begin
      if (!m_drain) begin
        q = m_qcnt + int'(e_iv);
        cur = 1'b0; oth = 1'b0;
        for (int t = 0; t < NT; t++) begin
          if (thread_en[t] && !m_stall[t]) begin
            if ((t / 4) == int'(m_tgrp)) cur = 1'b1;
            else oth = 1'b1;
          end
        end
        if (oth && (q == Q || !cur)) begin
          m_drain = 1'b1;
          m_qcnt  = q;
        end else begin
          m_qcnt = (q == Q) ? 0 : q;
        end
        if (e_iv) m_last = e_tid;
      end else begin
        busy = 1'b0;
        for (int k = 0; k < L - 1; k++) if (m_pipe[k] >= 0) busy = 1'b1;
        if (!busy) begin
          m_drain = 1'b0;
          m_tgrp  = !m_tgrp;
          m_qcnt  = 0;
        end
      end
      for (int k = L - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = e_iv ? e_tid : -1;
      if (!e_iv && m_idle < 64'hFFFF_FFFF) m_idle++;
    end
    if (stall_valid) m_stall[stall_tid] = 1'b1;
    if (wake_valid)  m_stall[wake_tid]  = 1'b0;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (!rst) begin
      model_eval();
      chk("issue_valid", issue_valid, e_iv);
      if (e_iv) chk("issue_tid", issue_tid, e_tid);
      chk("tgrp", tgrp, m_tgrp);
      chk("wb_valid", wb_valid, e_wbv);
      if (e_wbv) chk("wb_tid", wb_tid, e_wbt);
`ifdef MT_SCHED_PERF_EN
      chk("idle_cycles", idle_cycles, m_idle);
`else
      chk("idle_cycles", idle_cycles, 0);
`endif
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic start(input logic [7:0] en);
    rst = 1'b1; thread_en = en; stall_valid = 1'b0; wake_valid = 1'b0; pipe_hold = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic int iss();
    return issue_valid ? int'(issue_tid) : -1;
  endfunction

  int s1_iss[10] = '{0, 1, 3, 0, -1, -1, 4, 5, 7, 4};
  int s1_wb[4]   = '{0, 1, 3, 0};
  int s2_iss[5]  = '{0, 2, -1, -1, 0};
  int s3_iss[9]  = '{-1, -1, 5, -1, -1, 5, -1, -1, 5};

  initial begin
    int early, late;

    // All threads enabled: quantum, drain and group switch.
    start(8'hFF);
    for (int c = 0; c < 10; c++) begin
      mid();
      chk("s1_issue", iss(), s1_iss[c]);
      if (c >= 2 && c <= 5) chk("s1_wb", wb_valid ? int'(wb_tid) : -1, s1_wb[c-2]);
      if (c == 5 || c == 6) chk("s1_tgrp", tgrp, (c == 6));
      tick();
    end

    // Threads 0 and 2 only: parity blocking, no switch on quantum.
    start(8'h05);
    for (int c = 0; c < 12; c++) begin
      mid();
      if (c < 5) chk("s2_issue", iss(), s2_iss[c]);
      if (c == 11) chk("s2_tgrp", tgrp, 0);
      tick();
    end

    // Thread 5 only: immediate drain to group 1.
    start(8'h20);
    for (int c = 0; c < 9; c++) begin
      mid();
      chk("s3_issue", iss(), s3_iss[c]);
      if (c == 0) chk("s3_tgrp0", tgrp, 0);
      if (c == 2) chk("s3_tgrp2", tgrp, 1);
`ifdef MT_SCHED_PERF_EN
      if (c == 5) chk("s3_idle", idle_cycles, 4);
`endif
      tick();
    end

    // Threads 0-3, stall then simultaneous stall/wake of thread 1.
    start(8'h0F);
    early = 0; late = 0;
    for (int c = 0; c < 15; c++) begin
      stall_valid = (c == 0) || (c == 10);
      stall_tid   = 3'd1;
      wake_valid  = (c == 10);
      wake_tid    = 3'd1;
      mid();
      if (issue_valid && issue_tid == 3'd1) begin
        if (c <= 10) early++;
        else late++;
      end
      tick();
    end
    stall_valid = 1'b0; wake_valid = 1'b0;
    chk("s4_stalled_no_issue", early, 0);
    chk("s4_woken_issues", (late > 0), 1);

    // pipe_hold for cycles 2-4 of the all-threads run.
    start(8'hFF);
    for (int c = 0; c < 10; c++) begin
      pipe_hold = (c >= 2 && c <= 4);
      mid();
      if (c >= 2 && c <= 4) begin
        chk("s5_hold_issue", issue_valid, 0);
        chk("s5_hold_wb", wb_valid, 0);
      end
      if (c == 5) begin
        chk("s5_wb_valid", wb_valid, 1);
        chk("s5_wb_tid", wb_tid, 0);
        chk("s5_issue", iss(), 3);
      end
      tick();
    end
    pipe_hold = 1'b0;

    // Reset during DRAIN discards the pipe.
    start(8'hFF);
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    chk("s6_wb_valid0", wb_valid, 0);
    chk("s6_wb_tid0", wb_tid, 0);
    chk("s6_tgrp", tgrp, 0);
    chk("s6_issue", iss(), 0);
    tick();
    mid();
    chk("s6_wb_valid1", wb_valid, 0);
    tick();

    // Randomized traffic against the model.
    start(8'hFF);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) thread_en = 8'($urandom);
      stall_valid = ($urandom_range(0, 5) == 0);
      stall_tid   = 3'($urandom);
      wake_valid  = ($urandom_range(0, 3) == 0);
      wake_tid    = ($urandom_range(0, 7) == 0) ? stall_tid : 3'($urandom);
      pipe_hold   = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; pipe_hold = 1'b0; stall_valid = 1'b0; wake_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
